// File: rtl/dac_mon_pkg.sv
// Shared types and field layout for the DAC SPI link monitor.
// Frame layout is cmd[23:20], addr[19:16], data[15:0], MSB first.
package dac_mon_pkg;

  localparam int FRAME_BITS = 24;

  localparam int CMD_MSB  = 23;
  localparam int CMD_LSB  = 20;
  localparam int ADDR_MSB = 19;
  localparam int ADDR_LSB = 16;
  localparam int DATA_MSB = 15;
  localparam int DATA_LSB = 0;

  localparam logic [3:0] CMD_WR_UPD = 4'b0011;

  typedef enum logic {
    IDLE,
    SHIFT
  } dac_mon_state_t;

endpackage

// File: rtl/dac_mon_sync.sv
// Multi-stage synchronizer plus registered edge detector.
// level is delayed to line up with the registered rise/fall strobes.
module dac_mon_sync #(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sq;
  logic              dq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sq   <= {STAGES{RST_VAL}};
      dq   <= RST_VAL;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      sq   <= {sq[STAGES-2:0], d};
      dq   <= sq[STAGES-1];
      rise <= sq[STAGES-1] & ~dq;
      fall <= ~sq[STAGES-1] & dq;
    end
  end

  assign level = dq;

endmodule

// File: rtl/dac_spi_monitor.sv
// Passive decoder of the VCTCXO tuning-DAC SPI frames.
// Define DAC_MON_TIMEOUT_EN to build the stale-link watchdog.
module dac_spi_monitor
  import dac_mon_pkg::*;
#(
  parameter int          FRAME_BITS     = dac_mon_pkg::FRAME_BITS,
  parameter int          SYNC_STAGES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 400_000_000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        sclk,
  input  logic        mosi,
  input  logic        sync_n,
  output logic [15:0] dac_code,
  output logic [3:0]  dac_cmd,
  output logic [3:0]  dac_addr,
  output logic        frame_valid,
  output logic        frame_err,
  output logic [15:0] frame_cnt,
  output logic        stale
);

  localparam int CW = $clog2(FRAME_BITS + 2);
  localparam logic [CW-1:0] FB_C  = CW'(FRAME_BITS);
  localparam logic [CW-1:0] FB1_C = CW'(FRAME_BITS + 1);

  logic sclk_lvl, sclk_rise, sclk_fall;
  logic mosi_lvl, mosi_rise, mosi_fall;
  logic sync_lvl, sync_rise, sync_fall;

  dac_mon_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk (
    .clk(clk), .rst_n(rst_n), .d(sclk),
    .level(sclk_lvl), .rise(sclk_rise), .fall(sclk_fall)
  );

  dac_mon_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_mosi (
    .clk(clk), .rst_n(rst_n), .d(mosi),
    .level(mosi_lvl), .rise(mosi_rise), .fall(mosi_fall)
  );

  dac_mon_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync (
    .clk(clk), .rst_n(rst_n), .d(sync_n),
    .level(sync_lvl), .rise(sync_rise), .fall(sync_fall)
  );

  logic unused_ok;
  assign unused_ok = ^{sclk_lvl, sclk_fall, mosi_rise,
                       mosi_fall, sync_lvl};

  dac_mon_state_t state, state_nxt;
  logic [FRAME_BITS-1:0] sh, sh_nxt;
  logic [CW-1:0]         bc, bc_nxt;
  logic [15:0]           code_nxt, cnt_nxt;
  logic [3:0]            cmd_nxt, addr_nxt;
  logic                  v_nxt, e_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      sh          <= '0;
      bc          <= '0;
      dac_code    <= '0;
      dac_cmd     <= '0;
      dac_addr    <= '0;
      frame_valid <= 1'b0;
      frame_err   <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      state       <= state_nxt;
      sh          <= sh_nxt;
      bc          <= bc_nxt;
      dac_code    <= code_nxt;
      dac_cmd     <= cmd_nxt;
      dac_addr    <= addr_nxt;
      frame_valid <= v_nxt;
      frame_err   <= e_nxt;
      frame_cnt   <= cnt_nxt;
    end
  end

  // A sync_n rise wins over a coincident sclk rise: the frame
  // closes with the count it had before that cycle.
  always_comb begin
    state_nxt = state;
    sh_nxt    = sh;
    bc_nxt    = bc;
    code_nxt  = dac_code;
    cmd_nxt   = dac_cmd;
    addr_nxt  = dac_addr;
    cnt_nxt   = frame_cnt;
    v_nxt     = 1'b0;
    e_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        if (sync_fall) begin
          state_nxt = SHIFT;
          sh_nxt    = '0;
          bc_nxt    = '0;
        end
      end
      SHIFT: begin
        if (sync_rise) begin
          state_nxt = IDLE;
          if (bc == FB_C) begin
            cmd_nxt  = sh[CMD_MSB:CMD_LSB];
            addr_nxt = sh[ADDR_MSB:ADDR_LSB];
            code_nxt = sh[DATA_MSB:DATA_LSB];
            cnt_nxt  = frame_cnt + 16'd1;
            v_nxt    = 1'b1;
          end else begin
            e_nxt = 1'b1;
          end
        end else if (sclk_rise) begin
          sh_nxt = {sh[FRAME_BITS-2:0], mosi_lvl};
          if (bc != FB1_C) bc_nxt = bc + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef DAC_MON_TIMEOUT_EN
  localparam logic [28:0] TO_C = 29'(TIMEOUT_CYCLES);

  logic [28:0] wd;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd <= '0;
    end else if (v_nxt) begin
      wd <= '0;
    end else if (wd != '1) begin
      wd <= wd + 29'd1;
    end
  end

  assign stale = (wd >= TO_C);
`else
  logic unused_to;
  assign unused_to = TIMEOUT_CYCLES[0];
  assign stale     = 1'b0;
`endif

endmodule

// File: tb/tb_dac_spi_monitor.sv
// Scoreboard bench for dac_spi_monitor: directed SPI frames,
// expected strobes queued at each sync_n rise.
module tb_dac_spi_monitor;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        sclk   = 1'b0;
  logic        mosi   = 1'b0;
  logic        sync_n = 1'b1;
  logic [15:0] dac_code;
  logic [3:0]  dac_cmd;
  logic [3:0]  dac_addr;
  logic        frame_valid;
  logic        frame_err;
  logic [15:0] frame_cnt;
  logic        stale;

  dac_spi_monitor #(
    .FRAME_BITS(24),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(1000)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sclk(sclk),
    .mosi(mosi),
    .sync_n(sync_n),
    .dac_code(dac_code),
    .dac_cmd(dac_cmd),
    .dac_addr(dac_addr),
    .frame_valid(frame_valid),
    .frame_err(frame_err),
    .frame_cnt(frame_cnt),
    .stale(stale)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          valid;
    logic [15:0] code;
    logic [3:0]  cmd;
    logic [3:0]  addr;
    logic [15:0] cnt;
    int          t;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int failures = 0;
  int last_valid_cyc = 0;

  logic [15:0] m_code = '0;
  logic [3:0]  m_cmd  = '0;
  logic [3:0]  m_addr = '0;
  logic [15:0] m_cnt  = '0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push_exp(input logic [31:0] bits,
                          input int n);
    exp_t e;
    if (n == 24) begin
      m_cmd  = bits[23:20];
      m_addr = bits[19:16];
      m_code = bits[15:0];
      m_cnt  = m_cnt + 16'd1;
    end
    e.valid = (n == 24);
    e.code  = m_code;
    e.cmd   = m_cmd;
    e.addr  = m_addr;
    e.cnt   = m_cnt;
    e.t     = cyc;
    q.push_back(e);
  endtask

  // sclk at clk/8; align raises sclk together with sync_n
  task automatic send(input logic [31:0] bits,
                      input int n,
                      input bit align);
    sync_n = 1'b0;
    tick(4);
    for (int i = n - 1; i >= 0; i--) begin
      sclk = 1'b0;
      mosi = bits[i];
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
    sclk = 1'b0;
    tick(4);
    if (align) begin
      sclk = 1'b1;
      mosi = ~mosi;
    end
    sync_n = 1'b1;
    push_exp(bits, n);
    tick(8);
    sclk = 1'b0;
    tick(8);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_code"}, 32'(dac_code), 32'h0);
    chk({tag, "_cmd"}, 32'(dac_cmd), 32'h0);
    chk({tag, "_addr"}, 32'(dac_addr), 32'h0);
    chk({tag, "_valid"}, 32'(frame_valid), 32'h0);
    chk({tag, "_err"}, 32'(frame_err), 32'h0);
    chk({tag, "_cnt"}, 32'(frame_cnt), 32'h0);
    chk({tag, "_stale"}, 32'(stale), 32'h0);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_valid && frame_err)
        chk("both_strobes", 32'h1, 32'h0);
      if (frame_valid || frame_err) begin
        if (q.size() == 0) begin
          chk("unexpected_strobe", 32'(frame_valid), 32'h0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("kind_valid", 32'(frame_valid), 32'(e.valid));
          chk("kind_err", 32'(frame_err), 32'(!e.valid));
          chk("latency", 32'(cyc - e.t), 32'd4);
          chk("dac_code", 32'(dac_code), 32'(e.code));
          chk("dac_cmd", 32'(dac_cmd), 32'(e.cmd));
          chk("dac_addr", 32'(dac_addr), 32'(e.addr));
          chk("frame_cnt", 32'(frame_cnt), 32'(e.cnt));
        end
        if (frame_valid) last_valid_cyc = cyc;
      end
    end
  end

  initial begin
    #1 rst_n = 1'b0;
    tick(3);
    chk_reset_vals("rst0");
    rst_n = 1'b1;
    tick(4);

    send(32'h0030_8123, 24, 1'b0);
    send(32'h0012_3457, 23, 1'b0);
    send(32'h01AB_CDEF, 25, 1'b0);
    send(32'h0031_5A5A, 24, 1'b1);

    force dut.frame_cnt = 16'hFFFE;
    tick(1);
    release dut.frame_cnt;
    m_cnt = 16'hFFFE;
    send(32'h0030_0001, 24, 1'b0);
    send(32'h0030_0002, 24, 1'b0);

    sync_n = 1'b0;
    tick(4);
    for (int i = 0; i < 12; i++) begin
      sclk = 1'b0;
      mosi = 1'b1;
      tick(4);
      sclk = 1'b1;
      tick(4);
    end
    rst_n = 1'b0;
    tick(2);
    chk_reset_vals("rst1");
    sync_n = 1'b1;
    sclk = 1'b0;
    mosi = 1'b0;
    tick(3);
    rst_n = 1'b1;
    m_code = '0;
    m_cmd  = '0;
    m_addr = '0;
    m_cnt  = '0;
    tick(4);
    send(32'h0030_FFFF, 24, 1'b0);

`ifdef DAC_MON_TIMEOUT_EN
    begin
      int w;
      w = 0;
      while (!stale && w < 1200) begin
        tick(1);
        w++;
      end
      chk("stale_seen", 32'(stale), 32'h1);
      chk("stale_delay", 32'(cyc - last_valid_cyc), 32'd1000);
      send(32'h0030_1234, 24, 1'b0);
      chk("stale_clear", 32'(stale), 32'h0);
    end
`else
    chk("stale_off", 32'(stale), 32'h0);
`endif

    tick(20);
    chk("queue_drained", 32'(q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
